// File: rtl/tim_pkg.sv
// Shared definitions for the APB3 timer PWM sequencer:
// timer register map, PWM mode constant and sequencer state encoding.
package tim_pkg;

  localparam logic [7:0] OFS_CR1   = 8'h00;
  localparam logic [7:0] OFS_DIER  = 8'h0C;
  localparam logic [7:0] OFS_SR    = 8'h10;
  localparam logic [7:0] OFS_CCMR1 = 8'h18;
  localparam logic [7:0] OFS_CCMR2 = 8'h1C;
  localparam logic [7:0] OFS_CCER  = 8'h20;
  localparam logic [7:0] OFS_CNT   = 8'h24;
  localparam logic [7:0] OFS_PSC   = 8'h28;
  localparam logic [7:0] OFS_ARR   = 8'h2C;
  localparam logic [7:0] OFS_CCR1  = 8'h34;

  localparam logic [15:0] PWM_MODE1 = 16'h6060;
  localparam int unsigned INIT_STEPS = 10;

  typedef enum logic [2:0] {
    IDLE, INIT, RUN, UPD_CCR, UPD_SR, STOP
  } state_t;

  // Register written at each step of the bring-up sequence
  function automatic logic [7:0] init_ofs(
    input logic [3:0] step
  );
    case (step)
      4'd1:    init_ofs = OFS_PSC;
      4'd2:    init_ofs = OFS_ARR;
      4'd3:    init_ofs = OFS_CCMR1;
      4'd4:    init_ofs = OFS_CCMR2;
      4'd5:    init_ofs = OFS_CCER;
      4'd6:    init_ofs = OFS_CNT;
      4'd7:    init_ofs = OFS_SR;
      4'd8:    init_ofs = OFS_DIER;
      default: init_ofs = OFS_CR1;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy output.
// Pointers carry one wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;

  assign level = wptr - rptr;
  assign full  = level[AW];
  assign empty = (level == '0);
  assign dout  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/apb3_tim_pwm_sequencer.sv
// APB3 master that brings up one timer in PWM mode and reloads
// its compare register from a duty FIFO on every update interrupt.
module apb3_tim_pwm_sequencer
  import tim_pkg::*;
#(
  parameter logic [15:0] TIM_BASE = 16'h0000,
  parameter int          DEPTH    = 8
) (
  input  logic                   io_apb_PCLK,
  input  logic                   io_apb_PRESET,
  input  logic                   start,
  input  logic                   stop,
  input  logic [1:0]             cfg_ch,
  input  logic [15:0]            cfg_psc,
  input  logic [15:0]            cfg_arr,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [15:0]            s_data,
  input  logic                   tim_irq,
  output logic [15:0]            m_PADDR,
  output logic                   m_PSEL,
  output logic                   m_PENABLE,
  output logic                   m_PWRITE,
  output logic [31:0]            m_PWDATA,
  input  logic                   m_PREADY,
  input  logic [31:0]            m_PRDATA,
  input  logic                   m_PSLVERROR,
  output logic                   running,
  output logic                   busy,
  output logic                   underrun,
  output logic                   err,
  output logic [$clog2(DEPTH):0] fifo_level
);

  state_t      state;
  logic [3:0]  step;
  logic [3:0]  nstep;
  logic        stop_pend;
  logic [1:0]  ch;
  logic [15:0] psc;
  logic [15:0] arr;
  logic [15:0] wdata;
  logic [15:0] n_data;
  logic [15:0] head;
  logic [15:0] ccr_addr;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        done;
  logic        stop_now;
  logic        unused_prdata;

  assign unused_prdata = ^m_PRDATA;

  assign done     = m_PSEL & m_PENABLE & m_PREADY;
  assign stop_now = stop_pend | stop;
  assign push     = s_valid & s_ready;
  assign pop      = (state == UPD_CCR) & done;
  assign s_ready  = !fifo_full;
  assign busy     = m_PSEL;
  assign m_PWRITE = m_PSEL;
  assign m_PWDATA = {16'h0000, wdata};
  assign nstep    = step + 4'd1;
  assign ccr_addr = TIM_BASE + 16'(OFS_CCR1)
                  + {12'h000, ch, 2'b00};

  always_comb begin
    n_data = '0;
    case (nstep)
      4'd1:       n_data = psc;
      4'd2:       n_data = arr;
      4'd3, 4'd4: n_data = PWM_MODE1;
      4'd5:       n_data = 16'h0001 << {ch, 2'b00};
      4'd8, 4'd9: n_data = 16'h0001;
      default:    n_data = '0;
    endcase
  end

  sync_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_fifo (
    .clk   (io_apb_PCLK),
    .rst   (io_apb_PRESET),
    .push  (push),
    .din   (s_data),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Every new transfer starts in SETUP; back-to-back writes reuse PSEL
  always_ff @(posedge io_apb_PCLK or posedge io_apb_PRESET) begin
    if (io_apb_PRESET) begin
      state     <= IDLE;
      step      <= '0;
      stop_pend <= 1'b0;
      ch        <= '0;
      psc       <= '0;
      arr       <= '0;
      wdata     <= '0;
      m_PADDR   <= '0;
      m_PSEL    <= 1'b0;
      m_PENABLE <= 1'b0;
      running   <= 1'b0;
      underrun  <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (m_PSEL && !m_PENABLE) m_PENABLE <= 1'b1;
      if (done && m_PSLVERROR) err <= 1'b1;
      if (stop && (state == INIT || state == UPD_CCR
                   || state == UPD_SR))
        stop_pend <= 1'b1;
      unique case (state)
        IDLE: begin
          if (start && !stop) begin
            ch        <= cfg_ch;
            psc       <= cfg_psc;
            arr       <= cfg_arr;
            underrun  <= 1'b0;
            err       <= 1'b0;
            stop_pend <= 1'b0;
            step      <= '0;
            state     <= INIT;
            m_PSEL    <= 1'b1;
            m_PENABLE <= 1'b0;
            m_PADDR   <= TIM_BASE + 16'(OFS_CR1);
            wdata     <= '0;
          end
        end
        INIT: begin
          if (done) begin
            if (step == 4'(INIT_STEPS - 1)) begin
              if (stop_now) begin
                state     <= STOP;
                step      <= '0;
                stop_pend <= 1'b0;
                m_PENABLE <= 1'b0;
                m_PADDR   <= TIM_BASE + 16'(OFS_CR1);
                wdata     <= '0;
              end else begin
                state     <= RUN;
                running   <= 1'b1;
                m_PSEL    <= 1'b0;
                m_PENABLE <= 1'b0;
              end
            end else begin
              step      <= nstep;
              m_PENABLE <= 1'b0;
              m_PADDR   <= TIM_BASE + 16'(init_ofs(nstep));
              wdata     <= n_data;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state     <= STOP;
            step      <= '0;
            stop_pend <= 1'b0;
            m_PSEL    <= 1'b1;
            m_PENABLE <= 1'b0;
            m_PADDR   <= TIM_BASE + 16'(OFS_CR1);
            wdata     <= '0;
          end else if (tim_irq) begin
            m_PSEL    <= 1'b1;
            m_PENABLE <= 1'b0;
            if (!fifo_empty) begin
              state   <= UPD_CCR;
              m_PADDR <= ccr_addr;
              wdata   <= head;
            end else begin
              underrun <= 1'b1;
              state    <= UPD_SR;
              m_PADDR  <= TIM_BASE + 16'(OFS_SR);
              wdata    <= '0;
            end
          end
        end
        UPD_CCR: begin
          if (done) begin
            state     <= UPD_SR;
            m_PENABLE <= 1'b0;
            m_PADDR   <= TIM_BASE + 16'(OFS_SR);
            wdata     <= '0;
          end
        end
        UPD_SR: begin
          if (done) begin
            if (stop_now) begin
              state     <= STOP;
              step      <= '0;
              stop_pend <= 1'b0;
              m_PENABLE <= 1'b0;
              m_PADDR   <= TIM_BASE + 16'(OFS_CR1);
              wdata     <= '0;
            end else begin
              state     <= RUN;
              m_PSEL    <= 1'b0;
              m_PENABLE <= 1'b0;
            end
          end
        end
        STOP: begin
          if (done) begin
            if (step == 4'd0) begin
              step      <= 4'd1;
              m_PENABLE <= 1'b0;
              m_PADDR   <= TIM_BASE + 16'(OFS_DIER);
              wdata     <= '0;
            end else begin
              state     <= IDLE;
              running   <= 1'b0;
              m_PSEL    <= 1'b0;
              m_PENABLE <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
